// File: rtl/sobel_frame_arb_pkg.sv
// Shared types for the Sobel frame arbiter: FSM states,
// counter width and source index.
package sobel_frame_arb_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } arb_state_t;

  typedef logic src_t;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/sobel_rr_pick.sv
// Two-way round-robin pick: one-hot winner, ptr names the
// source favoured when both sources request.
module sobel_rr_pick
  import sobel_frame_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  src_t       ptr,
  output logic [1:0] win
);

  assign win[0] = req0 & (~req1 | (ptr == 1'b0));
  assign win[1] = req1 & (~req0 | (ptr == 1'b1));

endmodule

// File: rtl/sobel_frame_arb.sv
// Frame-locked two-source arbiter feeding a Sobel datapath.
// Optional idle abort: define SOBEL_ARB_TIMEOUT_EN.
module sobel_frame_arb
  import sobel_frame_arb_pkg::*;
#(
  parameter logic [7:0]  COL_MAX = 8'd4,
  parameter logic [7:0]  ROW_MAX = 8'd6,
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  input  logic [7:0] s0_data,
  input  logic [7:0] s1_data,
  input  logic       s0_flag,
  input  logic       s1_flag,
  output logic [7:0] pi_data,
  output logic       pi_flag,
  input  logic       po_flag,
  output logic       sobel_rst_n,
  output logic       busy,
  output logic       frame_done,
  output logic       err_timeout
);

  localparam cnt_t IN_TOTAL =
    cnt_t'(COL_MAX) * cnt_t'(ROW_MAX);
  localparam cnt_t OUT_TOTAL =
    (cnt_t'(COL_MAX) - cnt_t'(2)) *
    (cnt_t'(ROW_MAX) - cnt_t'(2));
  localparam cnt_t IN_LAST  = IN_TOTAL - cnt_t'(1);
  localparam cnt_t OUT_LAST = OUT_TOTAL - cnt_t'(1);

  arb_state_t state;
  src_t       src;
  src_t       ptr;
  cnt_t       in_cnt;
  cnt_t       out_cnt;
  logic [1:0] win;
  logic       g_flag;
  logic [7:0] g_data;
  logic       tmo_hit;

  sobel_rr_pick u_pick (
    .req0 (req0),
    .req1 (req1),
    .ptr  (ptr),
    .win  (win)
  );

  assign g_flag = src ? s1_flag : s0_flag;
  assign g_data = src ? s1_data : s0_data;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      src         <= 1'b0;
      ptr         <= 1'b0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      pi_data     <= '0;
      pi_flag     <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      sobel_rst_n <= 1'b0;
    end else begin
      pi_flag     <= 1'b0;
      frame_done  <= 1'b0;
      sobel_rst_n <= 1'b1;
      unique case (state)
        IDLE: begin
          if (|win) begin
            state   <= LOAD;
            src     <= win[1];
            gnt0    <= win[0];
            gnt1    <= win[1];
            busy    <= 1'b1;
            in_cnt  <= '0;
            out_cnt <= '0;
          end
        end
        LOAD: begin
          pi_data <= g_data;
          pi_flag <= g_flag;
          if (g_flag) begin
            in_cnt <= in_cnt + cnt_t'(1);
            if (in_cnt == IN_LAST) begin
              state <= DRAIN;
              gnt0  <= 1'b0;
              gnt1  <= 1'b0;
            end
          end else if (tmo_hit) begin
            state <= DONE;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
          end
        end
        DRAIN: begin
          if (po_flag) begin
            out_cnt <= out_cnt + cnt_t'(1);
            if (out_cnt == OUT_LAST) begin
              state      <= DONE;
              frame_done <= 1'b1;
            end
          end else if (tmo_hit) begin
            state <= DONE;
          end
        end
        DONE: begin
          state       <= IDLE;
          busy        <= 1'b0;
          ptr         <= ~src;
          sobel_rst_n <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SOBEL_ARB_TIMEOUT_EN
  cnt_t idle_cnt;
  logic idle_tick;

  assign idle_tick = (state == LOAD && !g_flag) ||
                     (state == DRAIN && !po_flag);
  assign tmo_hit = idle_tick &&
                   (idle_cnt == TIMEOUT - cnt_t'(1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idle_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      idle_cnt <= idle_tick ? idle_cnt + cnt_t'(1) : '0;
      // sticky until the next frame is granted
      if (state == IDLE && |win)
        err_timeout <= 1'b0;
      else if (tmo_hit)
        err_timeout <= 1'b1;
    end
  end
`else
  logic unused_tmo;

  assign unused_tmo  = ^TIMEOUT;
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule
